// File: rtl/da_platform_pkg.sv
// ----------------------------------------------------------------------------
// da_platform_pkg: command codes, slot constants and FSM state types. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package da_platform_pkg;

  localparam int HOST_WIDTH = 16;
  localparam int NUM_SLOTS  = 4;

  localparam logic [7:0] CMD_FIFO_WRITE   = 8'h20;
  localparam logic [7:0] AUD_FIFO_WRITE   = 8'h10;
  localparam logic [7:0] AUD_FIFO_READ    = 8'h11;
  localparam logic [7:0] UPDATE_BLOCKING  = 8'h40;
  localparam logic [7:0] FIFO_READ_STATUS = 8'h41;
  localparam logic [7:0] DEST_BROADCAST   = 8'hFF;

  localparam logic [7:0] SLOT_START_RECORDING = 8'h01;
  localparam logic [7:0] SLOT_STOP_RECORDING  = 8'h02;
  localparam logic [7:0] SPI_READ_REG         = 8'h10;
  localparam logic [7:0] SPI_WRITE_REG        = 8'h11;

  typedef enum logic [3:0] {
    ST_DEST, ST_CMD, ST_LEN_HI, ST_LEN_LO, ST_DATA,
    ST_CK_HI, ST_CK_LO, ST_SDATA, ST_WAIT
  } parser_state_t;

  typedef enum logic [3:0] {
    FR_IDLE, FR_DEST, FR_CMD, FR_CNT_HI, FR_CNT_LO,
    FR_RD, FR_SUM_HI, FR_SUM_LO, FR_LVL
  } frame_state_t;

  function automatic logic is_full_cmd(input logic [7:0] cmd);
    return (cmd == CMD_FIFO_WRITE) || (cmd == AUD_FIFO_WRITE);
  endfunction

  // Simple commands with no payload still consume one pad word.
  function automatic logic [23:0] simple_words(input logic [7:0] cmd);
    return (cmd == AUD_FIFO_READ) ? 24'd2 : 24'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/da_platform_if.sv
// ----------------------------------------------------------------------------
// da_platform_if: host, slot, read-FIFO and status signals of the engine. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface da_platform_if;
  import da_platform_pkg::*;

  logic [HOST_WIDTH-1:0]   host_in_data;
  logic                    host_in_valid;
  logic                    host_in_ready;
  logic [HOST_WIDTH-1:0]   host_out_data;
  logic                    host_out_valid;
  logic                    host_out_ready;
  logic [HOST_WIDTH-1:0]   slot_data;
  logic [7:0]              slot_id;
  logic                    slot_is_aud;
  logic                    slot_valid;
  logic                    slot_ready;
  logic [NUM_SLOTS-1:0]    blocking;
  logic [HOST_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [7:0]              rd_slot;
  logic [16*NUM_SLOTS-1:0] fifo_level;
  logic                    checksum_err;

  modport slave (
    input  host_in_data, host_in_valid, host_out_ready, slot_ready,
    input  rd_data, rd_valid, fifo_level,
    output host_in_ready, host_out_data, host_out_valid,
    output slot_data, slot_id, slot_is_aud, slot_valid, blocking,
    output rd_ready, rd_slot, checksum_err
  );

  modport master (
    output host_in_data, host_in_valid, host_out_ready, slot_ready,
    output rd_data, rd_valid, fifo_level,
    input  host_in_ready, host_out_data, host_out_valid,
    input  slot_data, slot_id, slot_is_aud, slot_valid, blocking,
    input  rd_ready, rd_slot, checksum_err
  );

endinterface

`default_nettype wire

// File: rtl/da_reply_framer.sv
// ----------------------------------------------------------------------------
// da_reply_framer: frames audio-read and FIFO-status replies onto host_out. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module da_reply_framer
  import da_platform_pkg::*;
(
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    i_start_rd,
  input  wire logic                    i_start_st,
  input  wire logic [7:0]              i_dest,
  input  wire logic [7:0]              i_cmd,
  input  wire logic [31:0]             i_count,
  input  wire logic [16*NUM_SLOTS-1:0] i_levels,
  output logic                         o_busy,
  output logic [15:0]                  o_data,
  output logic                         o_valid,
  input  wire logic                    i_ready,
  input  wire logic [15:0]             i_rd_data,
  input  wire logic                    i_rd_valid,
  output logic                         o_rd_ready,
  output logic [7:0]                   o_rd_slot
);

  localparam int IDX_W = $clog2(NUM_SLOTS);

  frame_state_t            r_fst, w_fst_nxt;
  logic [7:0]              r_dest, r_cmd;
  logic [31:0]             r_cnt, r_left, r_sum;
  logic [16*NUM_SLOTS-1:0] r_lvl;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_is_st;
  logic                    w_fire;

  assign w_fire    = o_valid & i_ready;
  assign o_busy    = (r_fst != FR_IDLE);
  assign o_rd_slot = r_dest;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fst <= FR_IDLE;
    else        r_fst <= w_fst_nxt;
  end

  always_comb begin
    w_fst_nxt  = r_fst;
    o_data     = '0;
    o_valid    = 1'b0;
    o_rd_ready = 1'b0;
    case (r_fst)
      FR_IDLE:   if (i_start_rd || i_start_st) w_fst_nxt = FR_DEST;
      FR_DEST: begin
        o_valid = 1'b1; o_data = {8'h00, r_dest};
        if (i_ready) w_fst_nxt = FR_CMD;
      end
      FR_CMD: begin
        o_valid = 1'b1; o_data = {8'h00, r_cmd};
        if (i_ready) w_fst_nxt = r_is_st ? FR_LVL : FR_CNT_HI;
      end
      FR_CNT_HI: begin
        o_valid = 1'b1; o_data = {8'h00, r_cnt[23:16]};
        if (i_ready) w_fst_nxt = FR_CNT_LO;
      end
      FR_CNT_LO: begin
        o_valid = 1'b1; o_data = r_cnt[15:0];
        if (i_ready) w_fst_nxt = (r_left == 32'd0) ? FR_SUM_HI : FR_RD;
      end
      FR_RD: begin
        // Audio words pass straight through; the host's ready drains the FIFO.
        o_valid    = i_rd_valid;
        o_data     = i_rd_data;
        o_rd_ready = i_ready;
        if (i_rd_valid && i_ready && r_left == 32'd1) w_fst_nxt = FR_SUM_HI;
      end
      FR_SUM_HI: begin
        o_valid = 1'b1; o_data = r_sum[31:16];
        if (i_ready) w_fst_nxt = FR_SUM_LO;
      end
      FR_SUM_LO: begin
        o_valid = 1'b1; o_data = r_sum[15:0];
        if (i_ready) w_fst_nxt = FR_IDLE;
      end
      FR_LVL: begin
        o_valid = 1'b1; o_data = r_lvl[{r_idx, 4'b0000} +: 16];
        if (i_ready && r_idx == IDX_W'(NUM_SLOTS - 1)) w_fst_nxt = FR_IDLE;
      end
      default:   w_fst_nxt = FR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dest  <= '0;
      r_cmd   <= '0;
      r_cnt   <= '0;
      r_left  <= '0;
      r_sum   <= '0;
      r_lvl   <= '0;
      r_idx   <= '0;
      r_is_st <= 1'b0;
    end else if (r_fst == FR_IDLE) begin
      if (i_start_rd || i_start_st) begin
        r_dest  <= i_start_st ? DEST_BROADCAST : i_dest;
        r_cmd   <= i_cmd;
        r_cnt   <= i_count;
        r_left  <= i_count;
        r_sum   <= '0;
        r_idx   <= '0;
        r_is_st <= i_start_st;
      end
    end else if (w_fire) begin
      case (r_fst)
        FR_CMD: if (r_is_st) r_lvl <= i_levels;
        FR_RD: begin
          r_sum  <= r_sum + {16'h0000, i_rd_data};
          r_left <= r_left - 32'd1;
        end
        FR_LVL:  r_idx <= r_idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/da_platform_core.sv
// ----------------------------------------------------------------------------
// da_platform_core: host word parser, slot router, blocking mask, reply issue. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module da_platform_core
  import da_platform_pkg::*;
(
  input  wire logic    clk_host,
  input  wire logic    reset,
  da_platform_if.slave bus
);

  parser_state_t        r_state, w_state_nxt;
  logic                 r_run;
  logic [7:0]           r_dest, r_cmd;
  logic [23:0]          r_len;
  logic [31:0]          r_sum;
  logic [15:0]          r_ck_hi, r_arg;
  logic [NUM_SLOTS-1:0] r_blocking;
  logic                 r_ck_err;
  logic                 w_in_ready, w_in_fire, w_drop, w_last_s;
  logic                 w_start_rd, w_start_st, w_busy;

  assign w_drop     = (r_dest == DEST_BROADCAST);
  assign w_in_fire  = bus.host_in_valid & w_in_ready;
  assign w_last_s   = (r_state == ST_SDATA) && w_in_fire && (r_len == 24'd1);
  assign w_start_rd = w_last_s && (r_cmd == AUD_FIFO_READ);
  assign w_start_st = w_last_s && (r_cmd == FIFO_READ_STATUS);

  assign bus.host_in_ready = w_in_ready;
  assign bus.slot_data     = bus.host_in_data;
  assign bus.slot_id       = r_dest;
  assign bus.slot_is_aud   = (r_cmd == AUD_FIFO_WRITE);
  assign bus.slot_valid    = (r_state == ST_DATA) && bus.host_in_valid && !w_drop;
  assign bus.blocking      = r_blocking;
  assign bus.checksum_err  = r_ck_err;

  always_ff @(posedge clk_host or negedge reset) begin
    if (!reset) r_state <= ST_DEST;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    if (r_run) begin
      case (r_state)
        ST_DATA: w_in_ready = bus.slot_ready | w_drop;
        ST_WAIT: w_in_ready = 1'b0;
        default: w_in_ready = 1'b1;
      endcase
    end
    case (r_state)
      ST_DEST:   if (w_in_fire) w_state_nxt = ST_CMD;
      ST_CMD:    if (w_in_fire)
                   w_state_nxt = is_full_cmd(bus.host_in_data[7:0]) ? ST_LEN_HI : ST_SDATA;
      ST_LEN_HI: if (w_in_fire) w_state_nxt = ST_LEN_LO;
      ST_LEN_LO: if (w_in_fire)
                   w_state_nxt = ({r_len[23:16], bus.host_in_data} == 24'd0) ? ST_CK_HI : ST_DATA;
      ST_DATA:   if (w_in_fire && r_len == 24'd1) w_state_nxt = ST_CK_HI;
      ST_CK_HI:  if (w_in_fire) w_state_nxt = ST_CK_LO;
      ST_CK_LO:  if (w_in_fire) w_state_nxt = ST_DEST;
      ST_SDATA:  if (w_last_s) w_state_nxt = (w_start_rd || w_start_st) ? ST_WAIT : ST_DEST;
      ST_WAIT:   if (!w_busy) w_state_nxt = ST_DEST;
      default:   w_state_nxt = ST_DEST;
    endcase
  end

  always_ff @(posedge clk_host or negedge reset) begin
    if (!reset) begin
      r_run      <= 1'b0;
      r_dest     <= '0;
      r_cmd      <= '0;
      r_len      <= '0;
      r_sum      <= '0;
      r_ck_hi    <= '0;
      r_arg      <= '0;
      r_blocking <= '0;
      r_ck_err   <= 1'b0;
    end else begin
      r_run    <= 1'b1;
      r_ck_err <= 1'b0;
      if (w_in_fire) begin
        case (r_state)
          ST_DEST:   r_dest <= bus.host_in_data[7:0];
          ST_CMD: begin
            r_cmd <= bus.host_in_data[7:0];
            r_len <= simple_words(bus.host_in_data[7:0]);
            r_sum <= '0;
          end
          ST_LEN_HI: r_len <= {bus.host_in_data[7:0], 16'h0000};
          ST_LEN_LO: r_len <= {r_len[23:16], bus.host_in_data};
          ST_DATA: begin
            r_sum <= r_sum + {16'h0000, bus.host_in_data};
            r_len <= r_len - 24'd1;
          end
          ST_CK_HI:  r_ck_hi <= bus.host_in_data;
          // Dropped broadcast packets never raise a checksum error.
          ST_CK_LO:  r_ck_err <= !w_drop && ({r_ck_hi, bus.host_in_data} != r_sum);
          ST_SDATA: begin
            r_arg <= bus.host_in_data;
            r_len <= r_len - 24'd1;
            if (r_len == 24'd1 && r_cmd == UPDATE_BLOCKING)
              r_blocking <= bus.host_in_data[NUM_SLOTS-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  da_reply_framer u_framer (
    .clk        (clk_host),
    .rst_n      (reset),
    .i_start_rd (w_start_rd),
    .i_start_st (w_start_st),
    .i_dest     (r_dest),
    .i_cmd      (r_cmd),
    .i_count    ({r_arg, bus.host_in_data}),
    .i_levels   (bus.fifo_level),
    .o_busy     (w_busy),
    .o_data     (bus.host_out_data),
    .o_valid    (bus.host_out_valid),
    .i_ready    (bus.host_out_ready),
    .i_rd_data  (bus.rd_data),
    .i_rd_valid (bus.rd_valid),
    .o_rd_ready (bus.rd_ready),
    .o_rd_slot  (bus.rd_slot)
  );

endmodule

`default_nettype wire

// File: tb/tb_da_platform_core.sv
// ----------------------------------------------------------------------------
// tb_da_platform_core: directed self-checking bench for da_platform_core. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_da_platform_core;
  import da_platform_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  da_platform_if bus();

  da_platform_core dut (
    .clk_host (clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  int          n_vec  = 0;
  int          n_err  = 0;
  int          ck_cnt = 0;
  int          rd_idx = 0;
  logic        rd_en  = 1'b0;
  logic        tog_en = 1'b0;
  logic [24:0] slot_q[$];
  logic [15:0] host_q[$];

  assign bus.rd_data  = 16'h0100 + rd_idx[15:0];
  assign bus.rd_valid = rd_en;

  always @(negedge clk) bus.slot_ready = tog_en ? ~bus.slot_ready : 1'b1;

  // Transfers are judged mid-cycle, then logged just after the edge that performs them.
  always begin : monitor
    logic        s_f, h_f, r_f;
    logic [24:0] s_w;
    logic [15:0] h_w;
    @(negedge clk); #2;
    s_f = bus.slot_valid & bus.slot_ready;
    s_w = {bus.slot_is_aud, bus.slot_id, bus.slot_data};
    h_f = bus.host_out_valid & bus.host_out_ready;
    h_w = bus.host_out_data;
    r_f = bus.rd_valid & bus.rd_ready;
    if (bus.checksum_err === 1'b1) ck_cnt++;
    @(posedge clk); #1;
    if (s_f) slot_q.push_back(s_w);
    if (h_f) host_q.push_back(h_w);
    if (r_f) rd_idx++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] w);
    int t = 0;
    @(negedge clk);
    bus.host_in_data  = w;
    bus.host_in_valid = 1'b1;
    #1;
    while (!bus.host_in_ready && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 300) chk("in_ready_timeout", {31'd0, bus.host_in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.host_in_valid = 1'b0;
  endtask

  task automatic wait_hq(input int n);
    int t = 0;
    while (host_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("host_out_count", host_q.size(), n);
  endtask

  task automatic aud_packet(input logic [15:0] ck_lo);
    send(16'h0000); send(16'h0010); send(16'h0000); send(16'h0200);
    for (int i = 0; i < 256; i++) begin
      send(16'h0000);
      send(i[15:0]);
    end
    send(16'h0000); send(ck_lo);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [24:0] e;
    bus.host_in_data   = '0;
    bus.host_in_valid  = 1'b0;
    bus.host_out_ready = 1'b1;
    bus.fifo_level     = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.host_in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.host_out_valid}, 32'd0);
    chk("rst_slot_valid", {31'd0, bus.slot_valid}, 32'd0);
    chk("rst_rd_ready", {31'd0, bus.rd_ready}, 32'd0);
    chk("rst_blocking", {28'd0, bus.blocking}, 32'd0);
    chk("rst_ck_err", {31'd0, bus.checksum_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Blocking mask updates
    send(16'h00FF); send(16'h0040); send(16'h0000);
    chk("blocking_0", {28'd0, bus.blocking}, 32'd0);
    send(16'h00FF); send(16'h0040); send(16'h0003);
    chk("blocking_3", {28'd0, bus.blocking}, 32'd3);
    repeat (3) @(negedge clk);
    chk("blocking_no_reply", host_q.size(), 0);

    // Short command-FIFO write to slot 1
    ck_cnt = 0;
    send(16'h0001); send(16'h0020); send(16'h0000); send(16'h0002);
    send(16'h0001); send(16'h0000); send(16'h0000); send(16'h0001);
    repeat (3) @(negedge clk);
    chk("cmdwr_count", slot_q.size(), 2);
    if (slot_q.size() == 2) begin
      chk("cmdwr_w0", {7'd0, slot_q[0]}, {7'd0, 1'b0, 8'h01, 16'h0001});
      chk("cmdwr_w1", {7'd0, slot_q[1]}, {7'd0, 1'b0, 8'h01, 16'h0000});
    end
    chk("cmdwr_ck_ok", ck_cnt, 0);
    slot_q.delete();

    // Zero-length full packet: good then bad checksum
    send(16'h0002); send(16'h0020); send(16'h0000); send(16'h0000);
    send(16'h0000); send(16'h0000);
    repeat (3) @(negedge clk);
    chk("len0_no_words", slot_q.size(), 0);
    chk("len0_ck_ok", ck_cnt, 0);
    send(16'h0002); send(16'h0020); send(16'h0000); send(16'h0000);
    send(16'h0000); send(16'h0001);
    repeat (3) @(negedge clk);
    chk("len0_ck_bad", ck_cnt, 1);

    // 512-word audio write with a stalling slot sink
    ck_cnt = 0;
    tog_en = 1'b1;
    aud_packet(16'h7F80);
    chk("audwr_count", slot_q.size(), 512);
    for (int k = 0; k < 512 && k < slot_q.size(); k++) begin
      e = {1'b1, 8'h00, 16'h0000};
      if (k[0]) e[15:0] = 16'(k / 2);
      chk("audwr_word", {7'd0, slot_q[k]}, {7'd0, e});
    end
    chk("audwr_ck_ok", ck_cnt, 0);
    slot_q.delete();
    aud_packet(16'h7F81);
    chk("audwr2_count", slot_q.size(), 512);
    chk("audwr2_ck_pulse", ck_cnt, 1);
    slot_q.delete();
    tog_en = 1'b0;

    // Unknown command consumes one pad word, nothing else
    send(16'h0002); send(16'h0055); send(16'h1234);
    repeat (3) @(negedge clk);
    chk("unk_blocking", {28'd0, bus.blocking}, 32'd3);
    chk("unk_no_reply", host_q.size(), 0);
    chk("unk_no_slot", slot_q.size(), 0);

    // Audio read of zero words: header + zero checksum
    rd_en = 1'b1;
    send(16'h0001); send(16'h0011); send(16'h0000); send(16'h0000);
    wait_hq(6);
    if (host_q.size() == 6) begin
      chk("rd0_dest", host_q[0], 16'h0001);
      chk("rd0_cmd", host_q[1], 16'h0011);
      chk("rd0_cnt_hi", host_q[2], 16'h0000);
      chk("rd0_cnt_lo", host_q[3], 16'h0000);
      chk("rd0_sum_hi", host_q[4], 16'h0000);
      chk("rd0_sum_lo", host_q[5], 16'h0000);
    end
    host_q.delete();

    // Audio read of 64 words 0x0100..0x013F: sum = 0x000047E0
    send(16'h0001); send(16'h0011); send(16'h0000); send(16'h0040);
    @(negedge clk); #1;
    chk("rd_parser_blocked", {31'd0, bus.host_in_ready}, 32'd0);
    chk("rd_slot", {24'd0, bus.rd_slot}, 32'h01);
    wait_hq(70);
    if (host_q.size() == 70) begin
      chk("rd_dest", host_q[0], 16'h0001);
      chk("rd_cmd", host_q[1], 16'h0011);
      chk("rd_cnt_hi", host_q[2], 16'h0000);
      chk("rd_cnt_lo", host_q[3], 16'h0040);
      for (int k = 0; k < 64; k++) chk("rd_word", host_q[4 + k], 16'h0100 + 16'(k));
      chk("rd_sum_hi", host_q[68], 16'h0000);
      chk("rd_sum_lo", host_q[69], 16'h47E0);
    end
    host_q.delete();
    rd_en = 1'b0;

    // FIFO status with the host stalled for 20 cycles
    bus.fifo_level     = {16'd40, 16'd30, 16'd20, 16'd10};
    bus.host_out_ready = 1'b0;
    send(16'h00FF); send(16'h0041); send(16'h0000);
    repeat (20) @(negedge clk);
    #1;
    chk("st_stall_valid", {31'd0, bus.host_out_valid}, 32'd1);
    chk("st_stall_data", {16'd0, bus.host_out_data}, 32'h00FF);
    chk("st_stall_nolost", host_q.size(), 0);
    bus.host_out_ready = 1'b1;
    wait_hq(6);
    if (host_q.size() == 6) begin
      chk("st_dest", host_q[0], 16'h00FF);
      chk("st_cmd", host_q[1], 16'h0041);
      chk("st_lvl0", host_q[2], 16'h000A);
      chk("st_lvl1", host_q[3], 16'h0014);
      chk("st_lvl2", host_q[4], 16'h001E);
      chk("st_lvl3", host_q[5], 16'h0028);
    end
    host_q.delete();

    // Reset in the middle of a packet discards it
    send(16'h0001); send(16'h0020); send(16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_in_ready", {31'd0, bus.host_in_ready}, 32'd0);
    chk("midrst_blocking", {28'd0, bus.blocking}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(16'h00FF); send(16'h0040); send(16'h0005);
    chk("midrst_fresh_cmd", {28'd0, bus.blocking}, 32'd5);
    repeat (3) @(negedge clk);
    chk("midrst_no_slot", slot_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
